// File: rtl/decode_pkg.sv
// Shared definitions for the multi-lane RV32I decode stage: opcodes, control encodings, uop layout.
package decode_pkg;

    localparam int unsigned UOP_W = 108;

    // Bit offsets of each field inside a packed uop (LSB first)
    localparam int unsigned UOP_PC_LSB      = 0;
    localparam int unsigned UOP_OPCODE_LSB  = 32;
    localparam int unsigned UOP_FUNCT3_LSB  = 39;
    localparam int unsigned UOP_FUNCT7_LSB  = 42;
    localparam int unsigned UOP_RS1_LSB     = 49;
    localparam int unsigned UOP_RS2_LSB     = 54;
    localparam int unsigned UOP_RD_LSB      = 59;
    localparam int unsigned UOP_IMM_LSB     = 64;
    localparam int unsigned UOP_ALUOP_LSB   = 96;
    localparam int unsigned UOP_LSFLAG_LSB  = 98;
    localparam int unsigned UOP_CTRL_LSB    = 100;
    localparam int unsigned UOP_JUMP_BIT    = 106;
    localparam int unsigned UOP_ILLEGAL_BIT = 107;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_IMM    = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    // ctrl = {regWrite, aluSrc, branch, memRead, memWrite, memToReg}
    localparam logic [5:0] CTRL_R      = 6'b100000;
    localparam logic [5:0] CTRL_IMM    = 6'b110000;
    localparam logic [5:0] CTRL_LOAD   = 6'b110101;
    localparam logic [5:0] CTRL_STORE  = 6'b010010;
    localparam logic [5:0] CTRL_BRANCH = 6'b001000;
    localparam logic [5:0] CTRL_JAL    = 6'b100000;

    localparam logic [1:0] ALU_ADD    = 2'b00;
    localparam logic [1:0] ALU_BRANCH = 2'b01;
    localparam logic [1:0] ALU_FUNCT  = 2'b10;
    localparam logic [1:0] ALU_LUI    = 2'b11;

    localparam logic [1:0] LS_NONE  = 2'b00;
    localparam logic [1:0] LS_STORE = 2'b01;
    localparam logic [1:0] LS_LOAD  = 2'b10;

    typedef struct packed {
        logic        illegal;
        logic        jump;
        logic [5:0]  ctrl;
        logic [1:0]  ls_flag;
        logic [1:0]  alu_op;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic [4:0]  rs2;
        logic [4:0]  rs1;
        logic [6:0]  funct7;
        logic [2:0]  funct3;
        logic [6:0]  opcode;
        logic [31:0] pc;
    } uop_t;

endpackage

// File: rtl/decode_lane.sv
// Combinational single-lane RV32I decoder: instruction + pc -> packed uop.
// Optional illegal-instruction detection is enabled by DECODE_ILLEGAL_CHK_EN.
module decode_lane
    import decode_pkg::*;
(
    input  logic [31:0] instr,
    input  logic [31:0] pc,
    output uop_t        uop_c
);

    logic [31:0] imm_i;
    logic [31:0] imm_s;
    logic [31:0] imm_b;
    logic [31:0] imm_u;
    logic [31:0] imm_j;

    assign imm_i = {{20{instr[31]}}, instr[31:20]};
    assign imm_s = {{20{instr[31]}}, instr[31:25], instr[11:7]};
    assign imm_b = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
    assign imm_u = {instr[31:12], 12'b0};
    assign imm_j = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};

    always_comb begin
        uop_c        = '0;
        uop_c.pc     = pc;
        uop_c.opcode = instr[6:0];
        uop_c.funct3 = instr[14:12];
        uop_c.funct7 = instr[31:25];
        uop_c.rs1    = instr[19:15];
        uop_c.rs2    = instr[24:20];
        uop_c.rd     = instr[11:7];

        case (instr[6:0])
            OP_R: begin
                uop_c.ctrl   = CTRL_R;
                uop_c.alu_op = ALU_FUNCT;
            end
            OP_IMM: begin
                uop_c.ctrl   = CTRL_IMM;
                uop_c.alu_op = ALU_FUNCT;
                uop_c.imm    = imm_i;
            end
            OP_LOAD: begin
                uop_c.ctrl    = CTRL_LOAD;
                uop_c.ls_flag = LS_LOAD;
                uop_c.imm     = imm_i;
            end
            OP_STORE: begin
                uop_c.ctrl    = CTRL_STORE;
                uop_c.ls_flag = LS_STORE;
                uop_c.imm     = imm_s;
            end
            OP_BRANCH: begin
                uop_c.ctrl   = CTRL_BRANCH;
                uop_c.alu_op = ALU_BRANCH;
                uop_c.imm    = imm_b;
            end
            OP_JAL: begin
                uop_c.ctrl = CTRL_JAL;
                uop_c.jump = 1'b1;
                uop_c.imm  = imm_j;
            end
            OP_JALR: begin
                uop_c.ctrl = CTRL_IMM;
                uop_c.jump = 1'b1;
                uop_c.imm  = imm_i;
            end
            OP_LUI: begin
                uop_c.ctrl   = CTRL_IMM;
                uop_c.alu_op = ALU_LUI;
                uop_c.imm    = imm_u;
            end
            OP_AUIPC: begin
                uop_c.ctrl   = CTRL_IMM;
                uop_c.alu_op = ALU_ADD;
                uop_c.imm    = imm_u;
            end
            default: ;
        endcase

`ifdef DECODE_ILLEGAL_CHK_EN
        case (instr[6:0])
            OP_R:    uop_c.illegal = !(instr[31:25] == 7'b0000000 || instr[31:25] == 7'b0100000);
            OP_LOAD: uop_c.illegal = (instr[14:12] == 3'b011) || (instr[14:12] == 3'b110)
                                     || (instr[14:12] == 3'b111);
            OP_IMM, OP_STORE, OP_BRANCH, OP_JAL, OP_JALR, OP_LUI, OP_AUIPC:
                     uop_c.illegal = 1'b0;
            default: uop_c.illegal = 1'b1;
        endcase
        // Illegal lanes keep fields and seq but must not cause any side effects downstream
        if (uop_c.illegal) begin
            uop_c.ctrl    = '0;
            uop_c.alu_op  = '0;
            uop_c.ls_flag = '0;
            uop_c.jump    = 1'b0;
        end
`else
        uop_c.illegal = 1'b0;
`endif
    end

endmodule

// File: rtl/decode_bundle.sv
// Multi-lane decode stage: parallel lane decode, sequence tagging, output register plus skid entry.
// Illegal-instruction detection in each lane is enabled by DECODE_ILLEGAL_CHK_EN.
module decode_bundle
    import decode_pkg::*;
#(
    parameter int unsigned WIDTH = 2,
    parameter int unsigned SEQ_W = 6,
    parameter int unsigned UOP_W = decode_pkg::UOP_W
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     inValid,
    output logic                     inReady,
    input  logic [31:0]              inPc,
    input  logic [32*WIDTH-1:0]      inInstr,
    input  logic [WIDTH-1:0]         inMask,
    output logic                     outValid,
    input  logic                     outReady,
    output logic [WIDTH-1:0]         outLaneValid,
    output logic [UOP_W*WIDTH-1:0]   outUop,
    output logic [SEQ_W*WIDTH-1:0]   outSeq
);

    uop_t [WIDTH-1:0]         lane_uop;
    logic [UOP_W*WIDTH-1:0]   in_uop;
    logic [SEQ_W*WIDTH-1:0]   in_seq;
    logic [SEQ_W-1:0]         seq_next;
    logic [SEQ_W-1:0]         seq_run;

    logic                     skid_valid;
    logic [WIDTH-1:0]         skid_lv;
    logic [UOP_W*WIDTH-1:0]   skid_uop;
    logic [SEQ_W*WIDTH-1:0]   skid_seq;
    logic                     accept;
    logic                     drain;

    for (genvar i = 0; i < WIDTH; i++) begin : g_lane
        decode_lane u_lane (
            .instr (inInstr[32*i +: 32]),
            .pc    (inPc + 32'(4 * i)),
            .uop_c (lane_uop[i])
        );
        assign in_uop[UOP_W*i +: UOP_W] = inMask[i] ? UOP_W'(lane_uop[i]) : '0;
    end

    // Tags are handed out in lane order to valid lanes only; seq_run ends at the next free tag
    always_comb begin
        in_seq  = '0;
        seq_run = seq_next;
        for (int i = 0; i < WIDTH; i++) begin
            if (inMask[i]) begin
                in_seq[SEQ_W*i +: SEQ_W] = seq_run;
                seq_run = seq_run + SEQ_W'(1);
            end
        end
    end

    assign inReady = !skid_valid && !flush;
    assign accept  = inValid && inReady;
    assign drain   = outValid && outReady;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            seq_next     <= '0;
            outValid     <= 1'b0;
            outLaneValid <= '0;
            outUop       <= '0;
            outSeq       <= '0;
            skid_valid   <= 1'b0;
            skid_lv      <= '0;
            skid_uop     <= '0;
            skid_seq     <= '0;
        end else if (flush) begin
            outValid   <= 1'b0;
            skid_valid <= 1'b0;
        end else begin
            if (accept) begin
                seq_next <= seq_run;
            end
            if (skid_valid && drain) begin
                outLaneValid <= skid_lv;
                outUop       <= skid_uop;
                outSeq       <= skid_seq;
                skid_valid   <= 1'b0;
            end else if (!outValid || drain) begin
                outValid <= accept;
                if (accept) begin
                    outLaneValid <= inMask;
                    outUop       <= in_uop;
                    outSeq       <= in_seq;
                end
            end else if (accept) begin
                skid_valid <= 1'b1;
                skid_lv    <= inMask;
                skid_uop   <= in_uop;
                skid_seq   <= in_seq;
            end
        end
    end

endmodule

// File: tb/tb_decode_bundle.sv
// Self-checking bench for decode_bundle: directed decode table, buffering corner cases,
// and randomized traffic checked against a queue-based reference model.
module tb_decode_bundle;
    import decode_pkg::*;

    localparam int unsigned W  = 2;
    localparam int unsigned SW = 6;
    localparam int unsigned UW = 108;
`ifdef DECODE_ILLEGAL_CHK_EN
    localparam logic ILL_EXP = 1'b1;
`else
    localparam logic ILL_EXP = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic              inValid;
    logic              inReady;
    logic [31:0]       inPc;
    logic [32*W-1:0]   inInstr;
    logic [W-1:0]      inMask;
    logic              outValid;
    logic              outReady;
    logic [W-1:0]      outLaneValid;
    logic [UW*W-1:0]   outUop;
    logic [SW*W-1:0]   outSeq;

    always #5 clk = ~clk;

    decode_bundle #(.WIDTH(W), .SEQ_W(SW), .UOP_W(UW)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .inValid(inValid), .inReady(inReady), .inPc(inPc), .inInstr(inInstr), .inMask(inMask),
        .outValid(outValid), .outReady(outReady), .outLaneValid(outLaneValid),
        .outUop(outUop), .outSeq(outSeq)
    );

    typedef struct {
        logic [W-1:0]    lv;
        logic [UW*W-1:0] uop;
        logic [SW*W-1:0] seq;
    } bundle_t;

    typedef struct {
        string       name;
        logic [31:0] ins;
        logic [31:0] imm;
        logic [5:0]  ctrl;
        logic [1:0]  alu;
        logic [1:0]  ls;
        logic        jmp;
        logic        ill;
    } vec_t;

    bundle_t      q[$];
    logic [SW-1:0] seq_model;
    int           tests;
    int           fails;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Reference decode written directly from the ISA rules using integer arithmetic
    function automatic logic [UW-1:0] ref_decode(input logic [31:0] ins, input logic [31:0] pc);
        int          imm;
        int          hi;
        logic [5:0]  ctrl;
        logic [1:0]  alu;
        logic [1:0]  ls;
        logic        jmp;
        logic        ill;
        imm = 0; ctrl = 0; alu = 0; ls = 0; jmp = 0; ill = 0;
        case (ins[6:0])
            7'h33: begin
                ctrl = 6'b100000; alu = 2'b10;
                ill = ILL_EXP && !(ins[31:25] == 7'h00 || ins[31:25] == 7'h20);
            end
            7'h13: begin ctrl = 6'b110000; alu = 2'b10; imm = $signed(ins) >>> 20; end
            7'h03: begin
                ctrl = 6'b110101; ls = 2'b10; imm = $signed(ins) >>> 20;
                ill = ILL_EXP && (ins[14:12] == 3 || ins[14:12] == 6 || ins[14:12] == 7);
            end
            7'h23: begin
                ctrl = 6'b010010; ls = 2'b01;
                hi = $signed(ins) >>> 25;
                imm = hi * 32 + int'(ins[11:7]);
            end
            7'h63: begin
                ctrl = 6'b001000; alu = 2'b01;
                hi = $signed(ins) >>> 31;
                imm = hi * 4096 + int'(ins[7]) * 2048 + int'(ins[30:25]) * 32 + int'(ins[11:8]) * 2;
            end
            7'h6F: begin
                ctrl = 6'b100000; jmp = 1;
                hi = $signed(ins) >>> 31;
                imm = hi * 1048576 + int'(ins[19:12]) * 4096 + int'(ins[20]) * 2048
                      + int'(ins[30:21]) * 2;
            end
            7'h67: begin ctrl = 6'b110000; jmp = 1; imm = $signed(ins) >>> 20; end
            7'h37: begin ctrl = 6'b110000; alu = 2'b11; imm = int'(ins & 32'hFFFFF000); end
            7'h17: begin ctrl = 6'b110000; imm = int'(ins & 32'hFFFFF000); end
            default: ill = ILL_EXP;
        endcase
        if (ill) begin ctrl = 0; alu = 0; ls = 0; jmp = 0; end
        return {ill, jmp, ctrl, ls, alu, 32'(imm), ins[11:7], ins[24:20], ins[19:15],
                ins[31:25], ins[14:12], ins[6:0], pc};
    endfunction

    function automatic bundle_t make_bundle(input logic [32*W-1:0] ins, input logic [31:0] pc,
                                            input logic [W-1:0] m, input logic [SW-1:0] s0);
        bundle_t b;
        b.lv = m; b.uop = '0; b.seq = '0;
        for (int i = 0; i < W; i++) begin
            if (m[i]) begin
                b.uop[i*UW +: UW] = ref_decode(ins[32*i +: 32], pc + 32'(4 * i));
                b.seq[i*SW +: SW] = SW'((int'(s0) + $countones(m & W'((1 << i) - 1))) % (1 << SW));
            end
        end
        return b;
    endfunction

    // One clock: compare outputs with the model at negedge, then advance the model on posedge
    task automatic step();
        logic    acc;
        logic    drn;
        bundle_t nb;
        @(negedge clk);
        chk("outValid", 256'(outValid), 256'(q.size() > 0));
        chk("inReady", 256'(inReady), 256'(q.size() < 2 && !flush));
        if (q.size() > 0) begin
            chk("outLaneValid", 256'(outLaneValid), 256'(q[0].lv));
            chk("outUop", 256'(outUop), 256'(q[0].uop));
            chk("outSeq", 256'(outSeq), 256'(q[0].seq));
        end
        acc = inValid && q.size() < 2 && !flush;
        drn = q.size() > 0 && outReady;
        nb  = make_bundle(inInstr, inPc, inMask, seq_model);
        @(posedge clk);
        if (flush) begin
            q.delete();
        end else begin
            if (drn) void'(q.pop_front());
            if (acc) begin
                q.push_back(nb);
                seq_model = SW'((int'(seq_model) + $countones(inMask)) % (1 << SW));
            end
        end
        #1;
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] pool[12];
        logic [31:0] r;
        pool = '{32'hFFF00093, 32'h00112423, 32'h008000EF, 32'hFE000EE3, 32'h123450B7,
                 32'h00412083, 32'h0000007F, 32'h002081B3, 32'hFFFFF097, 32'hFFC08067,
                 32'h40208133, 32'h00013083};
        r = $urandom;
        case ($urandom_range(0, 3))
            0: return pool[$urandom_range(0, 11)];
            1: return r;
            default: return {r[31:7], pool[$urandom_range(0, 11)][6:0]};
        endcase
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t        vecs[10];
        logic [SW-1:0] s0;
        int          guard;

        vecs[0] = '{"addi",  32'hFFF00093, 32'hFFFFFFFF, 6'b110000, 2'b10, 2'b00, 1'b0, 1'b0};
        vecs[1] = '{"sw",    32'h00112423, 32'h00000008, 6'b010010, 2'b00, 2'b01, 1'b0, 1'b0};
        vecs[2] = '{"jal",   32'h008000EF, 32'h00000008, 6'b100000, 2'b00, 2'b00, 1'b1, 1'b0};
        vecs[3] = '{"beq",   32'hFE000EE3, 32'hFFFFFFFC, 6'b001000, 2'b01, 2'b00, 1'b0, 1'b0};
        vecs[4] = '{"lui",   32'h123450B7, 32'h12345000, 6'b110000, 2'b11, 2'b00, 1'b0, 1'b0};
        vecs[5] = '{"lw",    32'h00412083, 32'h00000004, 6'b110101, 2'b00, 2'b10, 1'b0, 1'b0};
        vecs[6] = '{"op7f",  32'h0000007F, 32'h00000000, 6'b000000, 2'b00, 2'b00, 1'b0, ILL_EXP};
        vecs[7] = '{"add",   32'h002081B3, 32'h00000000, 6'b100000, 2'b10, 2'b00, 1'b0, 1'b0};
        vecs[8] = '{"auipc", 32'hFFFFF097, 32'hFFFFF000, 6'b110000, 2'b00, 2'b00, 1'b0, 1'b0};
        vecs[9] = '{"jalr",  32'hFFC08067, 32'hFFFFFFFC, 6'b110000, 2'b00, 2'b00, 1'b1, 1'b0};

        tests = 0; fails = 0; seq_model = '0;
        rst_n = 1'b0; flush = 1'b0; inValid = 1'b0; outReady = 1'b1;
        inPc = '0; inInstr = '0; inMask = '0;

        @(negedge clk);
        chk("rst_outValid", 256'(outValid), 256'(0));
        chk("rst_outLaneValid", 256'(outLaneValid), 256'(0));
        chk("rst_outUop", 256'(outUop), 256'(0));
        chk("rst_outSeq", 256'(outSeq), 256'(0));
        chk("rst_inReady", 256'(inReady), 256'(1));
        rst_n = 1'b1;
        @(posedge clk); #1;

        // addi/sw pair from pc 0x100
        inValid = 1'b1; inPc = 32'h100; inInstr = {32'h00112423, 32'hFFF00093}; inMask = 2'b11;
        step();
        inValid = 1'b0;
        chk("b0_l0_imm", 256'(outUop[UOP_IMM_LSB +: 32]), 256'(32'hFFFFFFFF));
        chk("b0_l0_ctrl", 256'(outUop[UOP_CTRL_LSB +: 6]), 256'(6'b110000));
        chk("b0_l0_seq", 256'(outSeq[0 +: SW]), 256'(0));
        chk("b0_l1_pc", 256'(outUop[UW + UOP_PC_LSB +: 32]), 256'(32'h104));
        chk("b0_l1_imm", 256'(outUop[UW + UOP_IMM_LSB +: 32]), 256'(8));
        chk("b0_l1_ctrl", 256'(outUop[UW + UOP_CTRL_LSB +: 6]), 256'(6'b010010));
        chk("b0_l1_ls", 256'(outUop[UW + UOP_LSFLAG_LSB +: 2]), 256'(2'b01));
        chk("b0_l1_seq", 256'(outSeq[SW +: SW]), 256'(1));
        step();

        // Directed single-lane decode table
        for (int v = 0; v < 10; v++) begin
            inValid = 1'b1; inPc = 32'h2000 + 32'(v * 16);
            inInstr = {32'h00000013, vecs[v].ins}; inMask = 2'b01;
            step();
            chk({vecs[v].name, "_lv"}, 256'(outLaneValid), 256'(2'b01));
            chk({vecs[v].name, "_imm"}, 256'(outUop[UOP_IMM_LSB +: 32]), 256'(vecs[v].imm));
            chk({vecs[v].name, "_ctrl"}, 256'(outUop[UOP_CTRL_LSB +: 6]), 256'(vecs[v].ctrl));
            chk({vecs[v].name, "_alu"}, 256'(outUop[UOP_ALUOP_LSB +: 2]), 256'(vecs[v].alu));
            chk({vecs[v].name, "_ls"}, 256'(outUop[UOP_LSFLAG_LSB +: 2]), 256'(vecs[v].ls));
            chk({vecs[v].name, "_jump"}, 256'(outUop[UOP_JUMP_BIT]), 256'(vecs[v].jmp));
            chk({vecs[v].name, "_illegal"}, 256'(outUop[UOP_ILLEGAL_BIT]), 256'(vecs[v].ill));
        end
        inValid = 1'b0;
        step();

        // Back-pressure: two bundles fit, third is refused, both drain in order
        s0 = seq_model;
        outReady = 1'b0; inValid = 1'b1; inMask = 2'b11;
        for (int k = 0; k < 3; k++) begin
            inInstr = {rand_instr(), rand_instr()}; inPc = 32'h3000 + 32'(k * 8);
            step();
            if (k == 1) chk("bp_inReady_full", 256'(inReady), 256'(0));
        end
        outReady = 1'b1; inValid = 1'b0;
        step();
        chk("bp_second_seq0", 256'(outSeq[0 +: SW]), 256'(SW'(s0 + 2)));
        chk("bp_second_seq1", 256'(outSeq[SW +: SW]), 256'(SW'(s0 + 3)));
        step();
        chk("bp_empty", 256'(outValid), 256'(0));

        // Walk seqNext to 63, then mask 10 wraps it
        guard = 0;
        inValid = 1'b1;
        while (seq_model != SW'(63) && guard < 100) begin
            inInstr = {rand_instr(), rand_instr()};
            inMask = (SW'(63) - seq_model >= 2) ? 2'b11 : 2'b01;
            step();
            guard++;
        end
        chk("wrap_reach63", 256'(seq_model), 256'(63));
        inInstr = {32'h00112423, 32'hFFF00093}; inMask = 2'b10;
        step();
        chk("wrap_lv", 256'(outLaneValid), 256'(2'b10));
        chk("wrap_l0_uop", 256'(outUop[0 +: UW]), 256'(0));
        chk("wrap_l0_seq", 256'(outSeq[0 +: SW]), 256'(0));
        chk("wrap_l1_seq", 256'(outSeq[SW +: SW]), 256'(63));
        inMask = 2'b01;
        step();
        chk("wrap_next_seq", 256'(outSeq[0 +: SW]), 256'(0));
        inValid = 1'b0;
        step();

        // Flush with both entries full and a bundle on offer
        outReady = 1'b0; inValid = 1'b1; inMask = 2'b11;
        step();
        step();
        s0 = seq_model;
        flush = 1'b1;
        step();
        flush = 1'b0;
        chk("flush_outValid", 256'(outValid), 256'(0));
        outReady = 1'b1; inMask = 2'b01;
        step();
        chk("flush_seq_kept", 256'(outSeq[0 +: SW]), 256'(s0));
        inValid = 1'b0;
        step();

        // Randomized traffic
        for (int c = 0; c < 400; c++) begin
            flush    = ($urandom_range(0, 19) == 0);
            inValid  = ($urandom_range(0, 3) != 0);
            outReady = ($urandom_range(0, 2) != 0);
            inMask   = W'($urandom);
            inPc     = {$urandom, 2'b00} >> 0;
            inInstr  = {rand_instr(), rand_instr()};
            step();
        end
        flush = 1'b0; inValid = 1'b0; outReady = 1'b1;
        repeat (3) step();

        // Asynchronous reset while both entries are full
        outReady = 1'b0; inValid = 1'b1; inMask = 2'b11;
        step();
        step();
        inValid = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("arst_outValid", 256'(outValid), 256'(0));
        chk("arst_inReady", 256'(inReady), 256'(1));
        chk("arst_outSeq", 256'(outSeq), 256'(0));
        q.delete();
        seq_model = '0;
        @(negedge clk);
        rst_n = 1'b1; outReady = 1'b1;
        @(posedge clk); #1;
        inValid = 1'b1; inMask = 2'b11; inInstr = {32'h00112423, 32'hFFF00093};
        step();
        chk("arst_seq_restart", 256'(outSeq), 256'({SW'(1), SW'(0)}));
        inValid = 1'b0;
        step();

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
